// File: rtl/mul_rs_pkg.sv
// Shared types for the multiply reservation station: per-source operand state and the entry layout.
// Also provides the CDB snoop helper used for resident entries and for dispatch payloads.
package mul_rs_pkg;

  localparam int unsigned TAG_W_DEF = 5;

  typedef struct packed {
    logic                 rdy;
    logic [31:0]          val;
    logic [TAG_W_DEF-1:0] tag;
  } src_t;

  typedef struct packed {
    logic                 valid;
    logic                 mulh;
    logic [TAG_W_DEF-1:0] tag;
    src_t                 src1;
    src_t                 src2;
  } rs_entry_t;

  // A waiting source captures the broadcast value; an already-ready source keeps its own value.
  function automatic src_t snoop(input src_t s, input logic cdb_valid,
                                 input logic [TAG_W_DEF-1:0] cdb_tag,
                                 input logic [31:0] cdb_value);
    src_t r;
    r = s;
    if (cdb_valid && !s.rdy && (s.tag == cdb_tag)) begin
      r.rdy = 1'b1;
      r.val = cdb_value;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_rs_pick.sv
// Lowest-index priority picker: one-hot grant of the lowest set request bit, plus an any flag.
module mul_rs_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_grant,
  output logic         o_any
);

  logic w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_req[i] && !w_found) begin
        o_grant[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/mul_rs.sv
// Reservation station for the integer multiplier: dispatch, CDB wakeup, lowest-index issue,
// and tracking of the single op in flight (tag, mulh, squash) until its result is taken.
module mul_rs
  import mul_rs_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             dispatch_valid,
  output logic             dispatch_ready,
  input  logic [TAG_W-1:0] dispatch_tag,
  input  logic             dispatch_mulh,
  input  logic             dispatch_src1_rdy,
  input  logic [31:0]      dispatch_src1_val,
  input  logic [TAG_W-1:0] dispatch_src1_tag,
  input  logic             dispatch_src2_rdy,
  input  logic [31:0]      dispatch_src2_val,
  input  logic [TAG_W-1:0] dispatch_src2_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  output logic             issue_valid,
  input  logic             mul_ready,
  output logic [31:0]      issue_multiplier,
  output logic [31:0]      issue_multiplicand,
  input  logic             mul_retire,
  output logic             inflight_valid,
  output logic             inflight_kill,
  output logic [TAG_W-1:0] inflight_tag,
  output logic             inflight_mulh
);

  // Entry layout is fixed by the package, so the tag width must agree with it.
  if (TAG_W != TAG_W_DEF) begin : g_tag_w_check
    $error("mul_rs: TAG_W must equal mul_rs_pkg::TAG_W_DEF");
  end

  rs_entry_t        r_entries [DEPTH];
  rs_entry_t        w_entries_nxt [DEPTH];
  rs_entry_t        w_new;
  logic             r_busy;
  logic             r_inflight_valid;
  logic             r_inflight_kill;
  logic [TAG_W-1:0] r_inflight_tag;
  logic             r_inflight_mulh;

  logic [DEPTH-1:0] w_free;
  logic [DEPTH-1:0] w_ready;
  logic [DEPTH-1:0] w_alloc_oh;
  logic [DEPTH-1:0] w_sel_oh;
  logic             w_any_free;
  logic             w_any_ready;
  logic             w_disp_fire;
  logic             w_issue_fire;
  logic [TAG_W-1:0] w_iss_tag;
  logic             w_iss_mulh;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_free[i]  = !r_entries[i].valid;
      w_ready[i] = r_entries[i].valid && r_entries[i].src1.rdy && r_entries[i].src2.rdy;
    end
  end

  mul_rs_pick #(.N(DEPTH)) u_pick_free (
    .i_req   (w_free),
    .o_grant (w_alloc_oh),
    .o_any   (w_any_free)
  );

  mul_rs_pick #(.N(DEPTH)) u_pick_issue (
    .i_req   (w_ready),
    .o_grant (w_sel_oh),
    .o_any   (w_any_ready)
  );

  assign dispatch_ready = w_any_free;
  assign issue_valid    = w_any_ready && !r_busy;
  assign w_disp_fire    = dispatch_valid && dispatch_ready;
  assign w_issue_fire   = issue_valid && mul_ready;

  always_comb begin
    issue_multiplier   = '0;
    issue_multiplicand = '0;
    w_iss_tag          = '0;
    w_iss_mulh         = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_sel_oh[i]) begin
        issue_multiplier   = issue_multiplier | r_entries[i].src1.val;
        issue_multiplicand = issue_multiplicand | r_entries[i].src2.val;
        w_iss_tag          = w_iss_tag | r_entries[i].tag;
        w_iss_mulh         = w_iss_mulh | r_entries[i].mulh;
      end
    end
  end

  // Dispatch payload merges a same-cycle CDB broadcast so it is never missed.
  always_comb begin
    w_new       = '0;
    w_new.valid = 1'b1;
    w_new.mulh  = dispatch_mulh;
    w_new.tag   = dispatch_tag;
    w_new.src1  = snoop('{rdy: dispatch_src1_rdy, val: dispatch_src1_val, tag: dispatch_src1_tag},
                        cdb_valid, cdb_tag, cdb_value);
    w_new.src2  = snoop('{rdy: dispatch_src2_rdy, val: dispatch_src2_val, tag: dispatch_src2_tag},
                        cdb_valid, cdb_tag, cdb_value);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_entries_nxt[i] = r_entries[i];
      if (r_entries[i].valid) begin
        w_entries_nxt[i].src1 = snoop(r_entries[i].src1, cdb_valid, cdb_tag, cdb_value);
        w_entries_nxt[i].src2 = snoop(r_entries[i].src2, cdb_valid, cdb_tag, cdb_value);
      end
      if (w_issue_fire && w_sel_oh[i]) begin
        w_entries_nxt[i].valid = 1'b0;
      end
      if (w_disp_fire && w_alloc_oh[i]) begin
        w_entries_nxt[i] = w_new;
      end
      if (flush) begin
        w_entries_nxt[i].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= w_entries_nxt[i];
      end
    end
  end

  // The multiplier cannot be aborted: a squashed op keeps busy set until its result is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy           <= 1'b0;
      r_inflight_valid <= 1'b0;
      r_inflight_kill  <= 1'b0;
      r_inflight_tag   <= '0;
      r_inflight_mulh  <= 1'b0;
    end else if (mul_retire) begin
      r_busy           <= 1'b0;
      r_inflight_valid <= 1'b0;
      r_inflight_kill  <= 1'b0;
    end else if (w_issue_fire) begin
      r_busy           <= 1'b1;
      r_inflight_valid <= !flush;
      r_inflight_kill  <= flush;
      r_inflight_tag   <= w_iss_tag;
      r_inflight_mulh  <= w_iss_mulh;
    end else if (flush && r_busy) begin
      r_inflight_valid <= 1'b0;
      r_inflight_kill  <= 1'b1;
    end
  end

  assign inflight_valid = r_inflight_valid;
  assign inflight_kill  = r_inflight_kill;
  assign inflight_tag   = r_inflight_tag;
  assign inflight_mulh  = r_inflight_mulh;

endmodule

// File: tb/tb_mul_rs.sv
// Directed bench for mul_rs: expected issues are queued as stimulus is driven and
// compared when the station hands an op to the multiplier.
module tb_mul_rs;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             dispatch_valid;
  logic             dispatch_ready;
  logic [TAG_W-1:0] dispatch_tag;
  logic             dispatch_mulh;
  logic             dispatch_src1_rdy;
  logic [31:0]      dispatch_src1_val;
  logic [TAG_W-1:0] dispatch_src1_tag;
  logic             dispatch_src2_rdy;
  logic [31:0]      dispatch_src2_val;
  logic [TAG_W-1:0] dispatch_src2_tag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;
  logic             issue_valid;
  logic             mul_ready;
  logic [31:0]      issue_multiplier;
  logic [31:0]      issue_multiplicand;
  logic             mul_retire;
  logic             inflight_valid;
  logic             inflight_kill;
  logic [TAG_W-1:0] inflight_tag;
  logic             inflight_mulh;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic             mulh;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  mul_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk                (clk),
    .reset              (reset),
    .flush              (flush),
    .dispatch_valid     (dispatch_valid),
    .dispatch_ready     (dispatch_ready),
    .dispatch_tag       (dispatch_tag),
    .dispatch_mulh      (dispatch_mulh),
    .dispatch_src1_rdy  (dispatch_src1_rdy),
    .dispatch_src1_val  (dispatch_src1_val),
    .dispatch_src1_tag  (dispatch_src1_tag),
    .dispatch_src2_rdy  (dispatch_src2_rdy),
    .dispatch_src2_val  (dispatch_src2_val),
    .dispatch_src2_tag  (dispatch_src2_tag),
    .cdb_valid          (cdb_valid),
    .cdb_tag            (cdb_tag),
    .cdb_value          (cdb_value),
    .issue_valid        (issue_valid),
    .mul_ready          (mul_ready),
    .issue_multiplier   (issue_multiplier),
    .issue_multiplicand (issue_multiplicand),
    .mul_retire         (mul_retire),
    .inflight_valid     (inflight_valid),
    .inflight_kill      (inflight_kill),
    .inflight_tag       (inflight_tag),
    .inflight_mulh      (inflight_mulh)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    flush          = 1'b0;
    dispatch_valid = 1'b0;
    cdb_valid      = 1'b0;
    mul_ready      = 1'b0;
    mul_retire     = 1'b0;
  endtask

  task automatic drive_disp(input logic [TAG_W-1:0] tag, input logic mulh,
                            input logic r1, input logic [31:0] v1, input logic [TAG_W-1:0] t1,
                            input logic r2, input logic [31:0] v2, input logic [TAG_W-1:0] t2);
    dispatch_valid    = 1'b1;
    dispatch_tag      = tag;
    dispatch_mulh     = mulh;
    dispatch_src1_rdy = r1;
    dispatch_src1_val = v1;
    dispatch_src1_tag = t1;
    dispatch_src2_rdy = r2;
    dispatch_src2_val = v2;
    dispatch_src2_tag = t2;
  endtask

  task automatic drive_cdb(input logic [TAG_W-1:0] tag, input logic [31:0] val);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_value = val;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input logic mulh);
    exp_t e;
    e.a    = a;
    e.b    = b;
    e.tag  = tag;
    e.mulh = mulh;
    sb_q.push_back(e);
  endtask

  // Waits (bounded) for an issue, compares it to the scoreboard head, then accepts it.
  task automatic do_issue(input string name);
    exp_t e;
    int   n;
    n = 0;
    while (issue_valid !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    chk({name, "_issue_valid"}, 64'(issue_valid), 64'(1));
    chk({name, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'(1));
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({name, "_multiplier"}, 64'(issue_multiplier), 64'(e.a));
      chk({name, "_multiplicand"}, 64'(issue_multiplicand), 64'(e.b));
      mul_ready = 1'b1;
      tick();
      mul_ready = 1'b0;
      chk({name, "_inflight_valid"}, 64'(inflight_valid), 64'(1));
      chk({name, "_inflight_tag"}, 64'(inflight_tag), 64'(e.tag));
      chk({name, "_inflight_mulh"}, 64'(inflight_mulh), 64'(e.mulh));
      chk({name, "_busy_blocks"}, 64'(issue_valid), 64'(0));
    end
  endtask

  task automatic do_retire(input string name);
    mul_retire = 1'b1;
    tick();
    mul_retire = 1'b0;
    chk({name, "_retired"}, 64'(inflight_valid), 64'(0));
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_dispatch_ready"}, 64'(dispatch_ready), 64'(1));
    chk({name, "_issue_valid"}, 64'(issue_valid), 64'(0));
    chk({name, "_inflight_valid"}, 64'(inflight_valid), 64'(0));
    chk({name, "_inflight_kill"}, 64'(inflight_kill), 64'(0));
    chk({name, "_inflight_tag"}, 64'(inflight_tag), 64'(0));
    chk({name, "_inflight_mulh"}, 64'(inflight_mulh), 64'(0));
    chk({name, "_multiplier"}, 64'(issue_multiplier), 64'(0));
    chk({name, "_multiplicand"}, 64'(issue_multiplicand), 64'(0));
  endtask

  initial begin
    reset = 1'b0;
    clear_in();
    drive_disp('0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    dispatch_valid = 1'b0;
    drive_cdb('0, '0);
    cdb_valid = 1'b0;
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Both sources ready: 7 x 6, tag 3; no same-cycle issue.
    drive_disp(5'd3, 1'b0, 1'b1, 32'd7, 5'd0, 1'b1, 32'd6, 5'd0);
    push_exp(32'd7, 32'd6, 5'd3, 1'b0);
    chk("t1_no_bypass", 64'(issue_valid), 64'(0));
    tick();
    clear_in();
    chk("t1_one_cycle", 64'(issue_valid), 64'(1));
    do_issue("t1");
    do_retire("t1");

    // src1 waits on tag 9, woken by a same-cycle broadcast of -7.
    drive_disp(5'd7, 1'b1, 1'b0, 32'd0, 5'd9, 1'b1, 32'd3, 5'd0);
    drive_cdb(5'd9, 32'hFFFF_FFF9);
    push_exp(32'hFFFF_FFF9, 32'd3, 5'd7, 1'b1);
    tick();
    clear_in();
    chk("t2_ready_next", 64'(issue_valid), 64'(1));
    do_issue("t2");
    do_retire("t2");

    // Fill all entries with ops waiting on tags 20..23.
    for (int i = 0; i < DEPTH; i++) begin
      chk("t3_ready_fill", 64'(dispatch_ready), 64'(1));
      drive_disp(5'(10 + i), 1'b0, 1'b0, 32'd0, 5'(20 + i), 1'b1, 32'd2, 5'd0);
      tick();
      clear_in();
    end
    chk("t3_full", 64'(dispatch_ready), 64'(0));
    drive_disp(5'd14, 1'b0, 1'b1, 32'd9, 5'd0, 1'b1, 32'd9, 5'd0);
    tick();
    clear_in();
    chk("t3_fifth_ignored", 64'(issue_valid), 64'(0));
    drive_cdb(5'd22, 32'd100);
    tick();
    clear_in();
    chk("t3_entry2_sel", 64'(issue_multiplier), 64'(100));
    drive_cdb(5'd20, 32'd50);
    tick();
    clear_in();
    push_exp(32'd50, 32'd2, 5'd10, 1'b0);
    push_exp(32'd100, 32'd2, 5'd12, 1'b0);
    do_issue("t3_first");
    chk("t3_ready_after_issue", 64'(dispatch_ready), 64'(1));
    do_retire("t3_first");
    do_issue("t3_second");
    do_retire("t3_second");

    // In-flight mulh op tag 5, then flush with dispatch and CDB in the same cycle.
    drive_disp(5'd5, 1'b1, 1'b1, 32'd5, 5'd0, 1'b1, 32'd5, 5'd0);
    push_exp(32'd5, 32'd5, 5'd5, 1'b1);
    tick();
    clear_in();
    do_issue("t4");
    flush = 1'b1;
    drive_disp(5'd6, 1'b0, 1'b1, 32'd8, 5'd0, 1'b1, 32'd8, 5'd0);
    drive_cdb(5'd21, 32'd1);
    tick();
    clear_in();
    chk("t4_kill_valid", 64'(inflight_valid), 64'(0));
    chk("t4_kill_set", 64'(inflight_kill), 64'(1));
    chk("t4_mulh_held", 64'(inflight_mulh), 64'(1));
    chk("t4_empty", 64'(dispatch_ready), 64'(1));
    tick();
    chk("t4_no_issue", 64'(issue_valid), 64'(0));
    mul_retire = 1'b1;
    tick();
    clear_in();
    chk("t4_kill_clear", 64'(inflight_kill), 64'(0));
    chk("t4_flushed_entries", 64'(issue_valid), 64'(0));
    drive_disp(5'd8, 1'b0, 1'b1, 32'd3, 5'd0, 1'b1, 32'd4, 5'd0);
    push_exp(32'd3, 32'd4, 5'd8, 1'b0);
    tick();
    clear_in();
    chk("t4_resume", 64'(issue_valid), 64'(1));
    do_issue("t4_after");
    do_retire("t4_after");

    // Async reset while busy with three entries resident.
    drive_disp(5'd15, 1'b0, 1'b1, 32'd2, 5'd0, 1'b1, 32'd3, 5'd0);
    push_exp(32'd2, 32'd3, 5'd15, 1'b0);
    tick();
    clear_in();
    do_issue("t5");
    drive_disp(5'd16, 1'b0, 1'b1, 32'd11, 5'd0, 1'b1, 32'd12, 5'd0);
    tick();
    drive_disp(5'd17, 1'b0, 1'b0, 32'd0, 5'd25, 1'b1, 32'd1, 5'd0);
    tick();
    drive_disp(5'd18, 1'b0, 1'b0, 32'd0, 5'd26, 1'b1, 32'd1, 5'd0);
    tick();
    clear_in();
    chk("t5_pre_mplier", 64'(issue_multiplier), 64'(11));
    chk("t5_pre_busy", 64'(inflight_valid), 64'(1));
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs("t5_async");
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Flush and retire together: retire wins, then normal issue.
    drive_disp(5'd2, 1'b0, 1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0);
    push_exp(32'd1, 32'd1, 5'd2, 1'b0);
    tick();
    clear_in();
    do_issue("t6");
    flush      = 1'b1;
    mul_retire = 1'b1;
    tick();
    clear_in();
    chk("t6_no_kill", 64'(inflight_kill), 64'(0));
    chk("t6_not_valid", 64'(inflight_valid), 64'(0));
    drive_disp(5'd4, 1'b1, 1'b1, 32'd6, 5'd0, 1'b0, 32'd0, 5'd0);
    drive_cdb(5'd0, 32'd7);
    push_exp(32'd6, 32'd7, 5'd4, 1'b1);
    chk("t6_no_bypass", 64'(issue_valid), 64'(0));
    tick();
    clear_in();
    chk("t6_issue_next", 64'(issue_valid), 64'(1));
    do_issue("t6_after");
    do_retire("t6_after");

    chk("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_rs.md
Name: mul_rs

Overview:
- Reservation station for the integer multiply functional unit.
- Accepts dispatched MUL/MULH ops from rename/dispatch and snoops the CDB for pending source operands.
- Issues one ready op at a time into the multiplier via its valid_in/ready handshake.
- Holds the in-flight op's ROB tag and mulh select stable until the multiplier's result is taken. The multiplier does not latch mulh, so it must be held externally.

Parameters:
DEPTH, 4, number of RS entries (power of two, >=2)
TAG_W, 5, ROB/physical tag width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
flush  input  1  synchronous squash of all entries (mispredict)
dispatch_valid  input  1  dispatch request
dispatch_ready  output  1  at least one free entry
dispatch_tag  input  TAG_W  destination ROB tag
dispatch_mulh  input  1  1 = return high word
dispatch_src1_rdy  input  1  src1 value valid
dispatch_src1_val  input  32  src1 value (multiplier)
dispatch_src1_tag  input  TAG_W  src1 producer tag
dispatch_src2_rdy  input  1  src2 value valid
dispatch_src2_val  input  32  src2 value (multiplicand)
dispatch_src2_tag  input  TAG_W  src2 producer tag
cdb_valid  input  1  CDB broadcast valid
cdb_tag  input  TAG_W  CDB producer tag
cdb_value  input  32  CDB value
issue_valid  output  1  drives multiplier valid_in
mul_ready  input  1  multiplier ready
issue_multiplier  output  32  selected entry src1
issue_multiplicand  output  32  selected entry src2
mul_retire  input  1  pulse = multiplier valid_out & yumi_in
inflight_valid  output  1  live op in multiplier
inflight_kill  output  1  op in multiplier was squashed; discard its result
inflight_tag  output  TAG_W  tag of op in multiplier
inflight_mulh  output  1  drives multiplier mulh

Behaviour:
- Reset (reset==0, async):
  - All entries are invalid; busy=0.
  - Outputs after reset: dispatch_ready=1, issue_valid=0, inflight_valid=0, inflight_kill=0, inflight_tag=0, inflight_mulh=0, issue_* data=0.
- Entry state: valid, tag, mulh, and per source {rdy, val, tag}. The entry is ready when valid & src1.rdy & src2.rdy.
- Dispatch:
  - Transfer on dispatch_valid & dispatch_ready.
  - Writes the lowest-index free entry at the clock edge.
  - dispatch_ready is computed from registered state only. An entry freed by issue in cycle N accepts dispatch from cycle N+1.
- CDB snoop:
  - Each cycle, every valid entry source with rdy=0 and tag==cdb_tag (when cdb_valid) captures cdb_value and sets rdy.
  - A dispatching op snoops the CDB in the same cycle. The dispatch payload's rdy/val are OR'd with the CDB match, so a same-cycle broadcast is never lost.
- Select:
  - Lowest-index ready entry, using registered state only.
  - Wakeup-to-issue and dispatch-to-issue latency are each 1 cycle minimum. There is no same-cycle bypass to issue.
- Issue:
  - issue_valid = (any ready entry) & ~busy.
  - issue_* data is driven combinationally from the selected entry.
  - Transfer on issue_valid & mul_ready. On transfer:
    - The entry is invalidated.
    - busy<=1, inflight_valid<=1, inflight_tag/inflight_mulh <= entry values, inflight_kill<=0.
- Retire:
  - mul_retire clears busy, inflight_valid and inflight_kill at the edge.
  - Issue resumes the following cycle; back-to-back ops are spaced by at least 1 idle cycle.
- Flush:
  - Invalidates all entries; dispatch/CDB in the same cycle are ignored.
  - If busy: inflight_valid<=0, inflight_kill<=1, busy stays 1 until mul_retire. The multiplier cannot be aborted; downstream must still assert yumi and drop the result.
  - Flush and mul_retire in the same cycle: retire wins, and the kill is not set.
- Simultaneous events:
  - Issue of entry k and CDB match on entry k in the same cycle: harmless, the entry is invalidated.
  - Full RS with an issue in the same cycle: dispatch_ready stays 0 that cycle.
- Tag 0 is a legal tag; matching is qualified only by cdb_valid and rdy=0.

Decomposition:
- Package mul_rs_pkg:
  - TAG_W default constant.
  - typedef src_t {rdy, val[31:0], tag}.
  - typedef rs_entry_t {valid, mulh, tag, src1, src2}.
- Sub-module mul_rs_pick: parameterised lowest-index priority encoder (DEPTH-bit request vector in; one-hot grant + any out). Used twice: once for free-entry allocation, once for issue select.

Test Plan:
- Both sources ready at dispatch, tag=3, 7×6, mulh=0:
  - Next cycle issue_valid=1 with multiplier=7, multiplicand=6.
  - After mul_ready transfer: inflight_tag=3, inflight_mulh=0.
  - mul_retire → inflight_valid=0.
- Dispatch src1 waiting on tag 9; CDB broadcasts tag 9, value -7, in the same cycle as dispatch:
  - Entry is ready.
  - Issues next cycle with multiplier=0xFFFFFFF9.
- Fill 4 entries, all waiting:
  - dispatch_ready=0 and a 5th dispatch is ignored.
  - CDB wakes entries 2 and 0 → entry 0 issues first.
  - After retire, entry 2 issues.
  - dispatch_ready=1 the cycle after the first issue.
- In-flight op tag 5 with mulh=1, then flush:
  - inflight_valid=0, inflight_kill=1, inflight_mulh held at 1.
  - RS empty and no issue until mul_retire.
  - After mul_retire, a new dispatch issues normally.
- Async reset asserted mid-operation (busy, 3 entries valid):
  - All outputs return immediately to reset values without a clock edge.
- Flush and mul_retire in the same cycle:
  - inflight_kill=0, busy=0.
  - A dispatch in the next cycle issues one cycle after that.
